// File: rtl/counter_mod_pkg.sv
// Shared encodings for the modulo-M counter: count modes and FSM states.
// Used by counter_mod_n and counter_mod_step.
package counter_mod_pkg;

  // 2'b11 is reserved and treated as wrap wherever a mode is decoded.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/counter_mod_step.sv
// Combinational next-count for one enabled step of the modulo-M counter.
// M arrives WIDTH+1 bits wide so that 2^WIDTH is representable.
module counter_mod_step
  import counter_mod_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   m,
  input  logic             up,
  input  mode_t            mode,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  logic [WIDTH:0] count_w;
  logic [WIDTH:0] sum;
  logic           clamp;

  assign count_w = {1'b0, count};
  assign sum     = count_w + STEP_W;
  assign clamp   = (mode == MODE_SAT) || (mode == MODE_ONESHOT);

  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    if (up) begin
      boundary = (sum >= m);
      if (!boundary)
        next_count = WIDTH'(sum);
      else if (clamp)
        next_count = WIDTH'(m - 1'b1);
      else
        next_count = WIDTH'(sum - m);
    end else begin
      boundary = (count_w < STEP_W);
      if (!boundary)
        next_count = WIDTH'(count_w - STEP_W);
      else if (clamp)
        next_count = '0;
      else
        next_count = WIDTH'(count_w + m - STEP_W);
    end
  end

endmodule

// File: rtl/counter_mod_n.sv
// Modulo-M up/down counter with wrap/saturate/one-shot modes, tc strobe and done flag.
// Optional snapshot register enabled by defining COUNTER_MOD_N_CAPTURE_EN.
module counter_mod_n
  import counter_mod_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int MOD_RESET = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic             i_up,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_mod,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_tc,
`ifdef COUNTER_MOD_N_CAPTURE_EN
  input  logic             i_cap,
  output logic [WIDTH-1:0] o_cap,
`endif
  output logic             o_done
);

  localparam logic [WIDTH:0] FULL_RANGE = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] r_mod;
  state_t           state;
  mode_t            mode;
  logic [WIDTH:0]   m_eff;
  logic [WIDTH:0]   m_new;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] step_next;
  logic             step_boundary;

  assign mode  = mode_t'(i_mode);
  assign m_eff = (r_mod == '0) ? FULL_RANGE : {1'b0, r_mod};
  assign m_new = (i_mod == '0) ? FULL_RANGE : {1'b0, i_mod};

  // Load compares against the modulus being captured on the same edge.
  assign ld_val = ({1'b0, i_data} < m_new) ? i_data : WIDTH'(m_new - 1'b1);

  counter_mod_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .count      (o_data),
    .m          (m_eff),
    .up         (i_up),
    .mode       (mode),
    .next_count (step_next),
    .boundary   (step_boundary)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mod  <= WIDTH'(MOD_RESET);
      o_data <= '0;
      o_tc   <= 1'b0;
      o_done <= 1'b0;
      state  <= ST_RUN;
    end else if (i_clr) begin
      r_mod  <= i_mod;
      o_data <= '0;
      o_tc   <= 1'b0;
      o_done <= 1'b0;
      state  <= ST_RUN;
    end else if (i_ld) begin
      r_mod  <= i_mod;
      o_data <= ld_val;
      o_tc   <= 1'b0;
      o_done <= 1'b0;
      state  <= ST_RUN;
    end else if (i_en && (state == ST_RUN)) begin
      o_data <= step_next;
      o_tc   <= step_boundary;
      if (step_boundary && (mode == MODE_ONESHOT)) begin
        state  <= ST_HALT;
        o_done <= 1'b1;
      end
    end else begin
      o_tc <= 1'b0;
    end
  end

`ifdef COUNTER_MOD_N_CAPTURE_EN
  // Snapshot sees the count visible this cycle, regardless of enable or HALT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_cap <= '0;
    else if (i_cap)
      o_cap <= o_data;
  end
`endif

endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench for counter_mod_n (WIDTH=8, STEP=3): directed cases then random traffic.
// Capture checks are active when COUNTER_MOD_N_CAPTURE_EN is defined.
module tb_counter_mod_n;

  localparam int W    = 8;
  localparam int STEP = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, clr, ld, up, cap;
  logic [1:0]   mode;
  logic [W-1:0] mod_in, data_in;
  logic [W-1:0] data_out;
  logic         tc, done;
`ifdef COUNTER_MOD_N_CAPTURE_EN
  logic [W-1:0] cap_out;
`endif

  always #5 clk = ~clk;

  counter_mod_n #(.WIDTH(W), .STEP(STEP), .MOD_RESET(0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_clr   (clr),
    .i_ld    (ld),
    .i_up    (up),
    .i_mode  (mode),
    .i_mod   (mod_in),
    .i_data  (data_in),
    .o_data  (data_out),
    .o_tc    (tc),
`ifdef COUNTER_MOD_N_CAPTURE_EN
    .i_cap   (cap),
    .o_cap   (cap_out),
`endif
    .o_done  (done)
  );

  typedef struct {
    int id;
    int data;
    int tc;
    int done;
    int cap;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   txn_id      = 0;

  // Reference model state: plain integers, M held as its true value (1..256).
  int m_cnt, m_mod, m_cap, m_tc, m_halt;

  function automatic void check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  function automatic void model_reset();
    m_cnt  = 0;
    m_mod  = 256;
    m_cap  = 0;
    m_tc   = 0;
    m_halt = 0;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict, enqueue.
  task automatic cyc(input int e, input int c, input int l, input int u, input int md,
                     input int mo, input int d, input int cp);
    int prev;
    int m_cand;
    @(negedge clk);
    en = e[0]; clr = c[0]; ld = l[0]; up = u[0]; cap = cp[0];
    mode = md[1:0]; mod_in = mo[W-1:0]; data_in = d[W-1:0];
    prev   = m_cnt;
    m_cand = (mo % 256 == 0) ? 256 : mo % 256;
    if (c != 0) begin
      m_mod = m_cand; m_cnt = 0; m_halt = 0; m_tc = 0;
    end else if (l != 0) begin
      m_mod = m_cand; m_halt = 0; m_tc = 0;
      m_cnt = ((d % 256) < m_mod) ? (d % 256) : m_mod - 1;
    end else if (e != 0 && m_halt == 0) begin
      if (u != 0) begin
        m_tc = (m_cnt + STEP >= m_mod) ? 1 : 0;
        if (m_tc == 0)          m_cnt = m_cnt + STEP;
        else if (md == 1 || md == 2) m_cnt = m_mod - 1;
        else                    m_cnt = (m_cnt + STEP) % m_mod;
      end else begin
        m_tc = (m_cnt < STEP) ? 1 : 0;
        if (m_tc == 0)          m_cnt = m_cnt - STEP;
        else if (md == 1 || md == 2) m_cnt = 0;
        else                    m_cnt = (m_cnt - STEP + m_mod) % m_mod;
      end
      if (m_tc != 0 && md == 2) m_halt = 1;
    end else begin
      m_tc = 0;
    end
    if (cp != 0) m_cap = prev;
    txn_id++;
    sb.push_back('{id: txn_id, data: m_cnt, tc: m_tc, done: m_halt, cap: m_cap});
  endtask

  task automatic idle_inputs();
    en = 0; clr = 0; ld = 0; up = 1; cap = 0; mode = 2'd0; mod_in = '0; data_in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, int'(data_out), 0);
    check({tag, "_tc"},   int'(tc),       0);
    check({tag, "_done"}, int'(done),     0);
`ifdef COUNTER_MOD_N_CAPTURE_EN
    check({tag, "_cap"},  int'(cap_out),  0);
`endif
  endtask

  // Monitor: the DUT presents a result one step after each queued transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %0d: data=%0d tc=%0d done=%0d (exp %0d/%0d/%0d)",
                 e.id, data_out, tc, done, e.data, e.tc, e.done);
        check("data", int'(data_out), e.data);
        check("tc",   int'(tc),       e.tc);
        check("done", int'(done),     e.done);
`ifdef COUNTER_MOD_N_CAPTURE_EN
        check("cap",  int'(cap_out),  e.cap);
`endif
      end
    end
  end

  initial begin
    int r;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Wrap up, M=10: 3, 6, 9, 2 (tc with 2); i_mod ignored while counting.
    cyc(0, 1, 0, 1, 0, 10, 0, 0);
    repeat (4) cyc(1, 0, 0, 1, 0, 77, 0, 0);

    // Full-range wrap down from 1: 254 with tc.
    cyc(0, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 99, 0, 0);

    // Saturate, M=5, load 9 -> 4, pinned steps keep firing tc.
    cyc(0, 0, 1, 1, 1, 5, 9, 0);
    repeat (3) cyc(1, 0, 0, 1, 1, 0, 0, 0);

    // One-shot: halts, holds with enable, mode change keeps HALT, load 0 releases.
    cyc(0, 0, 1, 1, 2, 5, 9, 0);
    repeat (3) cyc(1, 0, 0, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 2, 5, 0, 0);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);

    // Clear beats load; new modulus 20 is in effect afterwards.
    cyc(0, 1, 1, 1, 0, 20, 7, 0);
    repeat (8) cyc(1, 0, 0, 1, 0, 0, 0, 0);

    // Enter HALT, then asynchronous reset between edges.
    cyc(0, 0, 1, 1, 2, 6, 5, 0);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) cyc(1, 0, 0, 1, 0, 0, 0, 0);

    // Snapshot at 5, held while counting continues.
    cyc(0, 0, 1, 1, 0, 50, 2, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 1, 0, 0, 0, 0);

    // Random traffic with moduli above STEP (0 = full range).
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 255));
      if (r > 0 && r <= STEP) r = r + STEP;
      cyc(($urandom_range(0, 3) != 0) ? 1 : 0,
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          ($urandom_range(0, 14) == 0) ? 1 : 0,
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)),
          r,
          int'($urandom_range(0, 255)),
          ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
